spike_encoder: RTL
==================

# spike_encoder

Rate-coding input encoder for the spiking network: accepts one vector of per-channel intensities through a valid/ready handshake and emits a deterministic spike train per channel over a fixed window of timesteps. It sits in front of the hidden LIF layer, replacing raw `ui_in` bits as the spike source. It is the encoding counterpart of the `spike_counter` readout: over a full window of `2^WIDTH_P` ticks, each channel's spike count equals its intensity exactly.

## Interface
- `NUM_CHANNELS`, default 8: number of input channels.
- `WIDTH_P`, default 8: intensity width per channel.
- `WINDOW_LEN`, default 256: timesteps per sample. Legal range is 1..65535.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `intensity_i`  in  NUM_CHANNELS*WIDTH_P: packed intensities; channel c occupies bits [c*WIDTH_P +: WIDTH_P].
- `in_valid_i`  in  1: intensity vector offered.
- `in_ready_o`  out  1: encoder can accept a vector.
- `tick_i`  in  1: advance one timestep.
- `abort_i`  in  1: cancel the current sample.
- `spike_o`  out  NUM_CHANNELS: spikes for the current timestep.
- `spike_valid_o`  out  1: `spike_o` holds a timestep result.
- `busy_o`  out  1: a sample is being encoded.
- `done_o`  out  1: one-cycle pulse marking the final timestep of a window.
- `step_count_o`  out  $clog2(WINDOW_LEN+1): number of ticks consumed in the current window.

## Operation
- States:
  - IDLE: `in_ready_o`=1.
  - ENCODE: `busy_o`=1.
  - DONE: `busy_o`=1; lasts exactly one cycle.
- `in_ready_o`=(state==IDLE) and `busy_o`=(state!=IDLE), both decoded combinationally from the state register.
- Accept (IDLE, `in_valid_i`=1):
  - latch `intensity_i`;
  - clear all accumulators to 0;
  - clear `step_count_o` to 0;
  - go to ENCODE.
- ENCODE, on a cycle with `tick_i`=1, per channel:
  - sum = acc + I, computed at WIDTH_P+1 bits;
  - `spike_o[c]` <= sum[WIDTH_P];
  - acc <= sum[WIDTH_P-1:0];
  - `spike_valid_o` <= 1;
  - `step_count_o` += 1.
- ENCODE, on a cycle with `tick_i`=0: `spike_o` <= 0, `spike_valid_o` <= 0, accumulators hold.
- Spike rule: tick k (1-based) spikes iff floor(k·I/2^WIDTH_P) > floor((k-1)·I/2^WIDTH_P). Total spikes after N ticks = floor(N·I/2^WIDTH_P).
- The tick that brings the step count to WINDOW_LEN moves the state to DONE.
- In DONE, `done_o`=1 while `spike_valid_o`/`spike_o` show the final timestep. The state then returns to IDLE.
- `abort_i` in ENCODE:
  - state goes to IDLE on the next edge;
  - `spike_o` and `spike_valid_o` are 0 from that edge on;
  - no `done_o` pulse;
  - abort takes priority over a simultaneous `tick_i`.
- `abort_i` in IDLE has no effect. In DONE it is ignored; the DONE→IDLE transition proceeds.
- `in_valid_i` outside IDLE is ignored. `intensity_i` changes during ENCODE do not affect the sample in flight.
- I=0 never spikes. I=2^WIDTH_P-1 spikes on every tick except tick 1.

## Timing
- Reset: state IDLE, accumulators, latched intensities and `step_count_o` at 0, all outputs 0 except `in_ready_o`=1. Reset applies immediately (asynchronously), including mid-window.
- Accept at edge t. The earliest tick is sampled at edge t+1, and its spikes are visible after edge t+1.
- `spike_o` and `spike_valid_o` are registered, with a one-cycle latency from `tick_i`.
- With `tick_i` held high, `done_o` rises WINDOW_LEN cycles after the accept edge.
- After `done_o`, `in_ready_o` is 1 in the next cycle. Minimum sample period is WINDOW_LEN+2 cycles.

## Structure
- The shared `snn_pkg` package holds:
  - the encoder state enum (IDLE/ENCODE/DONE);
  - default `NUM_CHANNELS`/`WIDTH_P` constants, shared with the LIF layers and `spike_counter`.
- Sub-module `rate_accumulator`: one channel's accumulator register, adder and carry-out spike, with a clear input and a tick-enable input. It is instantiated NUM_CHANNELS times under generate.
- The FSM, step counter and handshake live in `spike_encoder`.

## Test plan
- Accept {0,1,37,64,128,192,254,255}, `tick_i`=1 constantly, WINDOW_LEN=256 -> per-channel spike totals exactly {0,1,37,64,128,192,254,255}; a single `done_o` pulse 256 cycles after accept.
- I=128 -> spikes on ticks 2,4,…,256. I=255 -> no spike on tick 1, spike on ticks 2..256. I=1 -> only tick 256 spikes.
- `tick_i` high every third cycle -> same totals as scenario 1; `spike_valid_o` high only in the cycle after each tick; `step_count_o` increments only on ticks; `done_o` arrives after the 256th tick.
- `abort_i` with `tick_i`=1 at step 100 -> IDLE next cycle, `in_ready_o`=1, no `done_o`, `step_count_o` stays at 100. A new sample with I=64 then restarts from acc 0 and yields 64 spikes.
- Drive `rst_ni` low mid-window -> outputs 0 and `in_ready_o`=1 without waiting for a clock edge; after release, a normal sample encodes correctly.
- `in_valid_i` held with changing data throughout ENCODE -> no accept until IDLE and the spike pattern matches the originally latched vector. The vector offered in the first IDLE cycle after DONE is accepted (back-to-back).

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking network: default layer dimensions and
// the rate-encoder state encoding.
package snn_pkg;

  // Default channel count and per-channel intensity width. The LIF layers
  // and spike_counter use the same defaults.
  localparam int unsigned NUM_CHANNELS_DEF = 8;
  localparam int unsigned WIDTH_P_DEF      = 8;

  // Default encoding window: one full accumulator period of 2^WIDTH_P ticks.
  localparam int unsigned WINDOW_LEN_DEF   = 256;

  // Rate-encoder FSM states.
  typedef enum logic [1:0] {
    ENC_IDLE   = 2'd0,
    ENC_ENCODE = 2'd1,
    ENC_DONE   = 2'd2
  } enc_state_e;

endpackage

// File: rtl/rate_accumulator.sv
// One channel of the rate encoder: a phase accumulator that adds the
// channel intensity on every enabled tick. The carry out of that addition
// is the channel's spike for the tick. Over 2^WIDTH_P ticks the carry
// fires exactly `intensity_i` times.
module rate_accumulator
  import snn_pkg::*;
#(
  parameter int unsigned WIDTH_P = WIDTH_P_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               tick_en_i,
  input  logic [WIDTH_P-1:0] intensity_i,
  output logic               carry_o
);

  logic [WIDTH_P-1:0] acc_q;
  logic [WIDTH_P:0]   sum;

  // Sum is one bit wider than the accumulator so the carry is the spike.
  assign sum     = {1'b0, acc_q} + {1'b0, intensity_i};
  assign carry_o = sum[WIDTH_P];

  // Accumulator register: clear wins over tick so each sample starts at phase 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (tick_en_i) begin
      acc_q <= sum[WIDTH_P-1:0];
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding input encoder. It accepts one vector of per-channel
// intensities and emits a deterministic spike train per channel, one
// timestep per tick, for WINDOW_LEN ticks. The final timestep is marked
// with a one-cycle done pulse. An abort cancels the sample without a done
// pulse.
//
// Handshake: a vector transfers on a rising clk_i edge where
// in_valid_i && in_ready_o. in_ready_o is high only in IDLE and depends
// only on the state register, never on in_valid_i. A vector offered while
// in_ready_o is low is neither consumed nor remembered. The source may
// change or drop it freely.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int unsigned WIDTH_P      = WIDTH_P_DEF,
  parameter int unsigned WINDOW_LEN   = WINDOW_LEN_DEF,
  localparam int unsigned SW          = $clog2(WINDOW_LEN + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_CHANNELS*WIDTH_P-1:0] intensity_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic                            tick_i,
  input  logic                            abort_i,
  output logic [NUM_CHANNELS-1:0]         spike_o,
  output logic                            spike_valid_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [SW-1:0]                   step_count_o,
  output enc_state_e                      dbg_state_o
);

  localparam logic [SW-1:0] LAST_STEP = SW'(WINDOW_LEN - 1);

  enc_state_e                      state_q, state_d;
  logic [NUM_CHANNELS*WIDTH_P-1:0] intensity_q;
  logic [SW-1:0]                   step_q;
  logic [NUM_CHANNELS-1:0]         spike_q;
  logic                            spike_valid_q;
  logic [NUM_CHANNELS-1:0]         carry;

  logic accept;
  logic tick_en;
  logic last_step;

  // A transfer happens only from IDLE. Abort suppresses a simultaneous tick.
  assign accept    = (state_q == ENC_IDLE) && in_valid_i;
  assign tick_en   = (state_q == ENC_ENCODE) && tick_i && !abort_i;
  assign last_step = (step_q == LAST_STEP);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ENC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ENC_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_d = ENC_ENCODE;
        end
      end
      ENC_ENCODE: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_d = ENC_IDLE;
        end else if (tick_i && last_step) begin
          state_d = ENC_DONE;
        end
      end
      ENC_DONE: begin
        // The final timestep is on spike_o during this cycle. Abort is ignored here.
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = ENC_IDLE;
      end
      default: begin
        state_d = ENC_IDLE;
      end
    endcase
  end

  // Latch the accepted vector. Later intensity_i changes do not reach the sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      intensity_q <= '0;
    end else if (accept) begin
      intensity_q <= intensity_i;
    end
  end

  // Step counter: cleared on accept and advanced once per effective tick.
  // It holds its value through abort and IDLE so software can read where a
  // cancelled sample stopped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q <= '0;
    end else if (accept) begin
      step_q <= '0;
    end else if (tick_en) begin
      step_q <= step_q + SW'(1);
    end
  end

  // Per-channel phase accumulators. Their carries are this tick's spikes.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    rate_accumulator #(
      .WIDTH_P (WIDTH_P)
    ) u_acc (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (accept),
      .tick_en_i   (tick_en),
      .intensity_i (intensity_q[c*WIDTH_P +: WIDTH_P]),
      .carry_o     (carry[c])
    );
  end

  // Spike output register: one cycle after a tick it shows that tick's
  // spikes. Otherwise it shows zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
    end else if (tick_en) begin
      spike_q       <= carry;
      spike_valid_q <= 1'b1;
    end else begin
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
    end
  end

  assign spike_o       = spike_q;
  assign spike_valid_o = spike_valid_q;
  assign step_count_o  = step_q;
  assign dbg_state_o   = state_q;

endmodule
